// File: rtl/select_decoder.sv
// rtl/select_decoder.sv - registered one-hot select generator with DECODE and dwell-timed SCAN modes
module select_decoder #(
    parameter int SEL_WIDTH   = 3,
    parameter int NUM_OUT     = 8,
    parameter int DWELL_WIDTH = 8,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   mode,
    input  logic                   load,
    input  logic [SEL_WIDTH-1:0]   sel,
    input  logic [DWELL_WIDTH-1:0] dwell,
    output logic [NUM_OUT-1:0]     y,
    output logic [SEL_WIDTH-1:0]   index,
    output logic                   valid,
    output logic                   wrap
);

    localparam logic [SEL_WIDTH:0]   NUM_OUT_W = (SEL_WIDTH+1)'(NUM_OUT);
    localparam logic [SEL_WIDTH-1:0] LAST_IDX  = SEL_WIDTH'(NUM_OUT - 1);
    localparam logic [NUM_OUT-1:0]   Y_OFF     = {NUM_OUT{ACTIVE_LOW != 0}};

    typedef enum logic [1:0] {ST_OFF, ST_DECODE, ST_SCAN} state_t;

    state_t                 state, state_n;
    logic [DWELL_WIDTH-1:0] cnt, cnt_n;
    logic [SEL_WIDTH-1:0]   idx_n;
    logic [NUM_OUT-1:0]     oh_n;
    logic                   valid_n, wrap_n, sel_ok;

    function automatic logic [NUM_OUT-1:0] onehot(input logic [SEL_WIDTH-1:0] i);
        logic [NUM_OUT-1:0] r;
        r = '0;
        for (int b = 0; b < NUM_OUT; b++) begin
            if (i == SEL_WIDTH'(b)) r[b] = 1'b1;
        end
        return r;
    endfunction

    assign sel_ok = ({1'b0, sel} < NUM_OUT_W);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_OFF;
            cnt   <= '0;
            index <= '0;
            y     <= Y_OFF;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            index <= idx_n;
            y     <= oh_n ^ Y_OFF;
            valid <= valid_n;
            wrap  <= wrap_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = index;
        oh_n    = '0;
        valid_n = 1'b0;
        wrap_n  = 1'b0;
        if (!en) begin
            state_n = ST_OFF;
        end else if (!mode) begin
            state_n = ST_DECODE;
            idx_n   = sel;
            oh_n    = onehot(sel);
            valid_n = sel_ok;
        end else begin
            state_n = ST_SCAN;
            valid_n = 1'b1;
            // Entry and load restart the walk; load deliberately pre-empts a due advance.
            if (state != ST_SCAN || load) begin
                idx_n = sel_ok ? sel : '0;
                cnt_n = dwell;
            end else if (cnt != '0) begin
                cnt_n = cnt - DWELL_WIDTH'(1);
            end else begin
                cnt_n = dwell;
                if (index >= LAST_IDX) begin
                    idx_n  = '0;
                    wrap_n = 1'b1;
                end else begin
                    idx_n = index + SEL_WIDTH'(1);
                end
            end
            oh_n = onehot(idx_n);
        end
    end

endmodule
